// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and its barrel shifter:
// operation encodings, FSM states and the per-pass step limit.
package shift_sequencer_pkg;

  localparam logic [2:0] SEL_LSR = 3'b000;
  localparam logic [2:0] SEL_LSL = 3'b001;
  localparam logic [2:0] SEL_ROR = 3'b010;
  localparam logic [2:0] SEL_ROL = 3'b011;
  localparam logic [2:0] SEL_ASR = 3'b100;

  // Largest amount the 16-bit shifter applies in one pass, and the width
  // of its amount input.
  localparam int MAX_STEP = 15;
  localparam int STEP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Selects 101/110/111 carry no operation.
  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel <= SEL_ASR);
  endfunction

endpackage

// File: rtl/shift_sequencer_barrel.sv
// Single-cycle 16-bit barrel shifter. Amount is limited to 0..15; an
// illegal select produces an all-zero result.
module BarrelShifter
  import shift_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [STEP_W-1:0]     step_i,
  input  logic [2:0]            select_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  // Rotates come from shifting a doubled copy of the operand.
  logic [2*DATA_WIDTH-1:0]      dbl_w;
  logic [2*DATA_WIDTH-1:0]      ror_w;
  logic [2*DATA_WIDTH-1:0]      rol_w;
  logic signed [DATA_WIDTH-1:0] sdata_w;
  logic signed [DATA_WIDTH-1:0] asr_w;

  assign dbl_w   = {data_i, data_i};
  assign ror_w   = dbl_w >> step_i;
  assign rol_w   = dbl_w << step_i;
  assign sdata_w = signed'(data_i);
  assign asr_w   = sdata_w >>> step_i;

  // Operation mux.
  always_comb begin
    result_o = '0;
    case (select_i)
      SEL_LSR: result_o = data_i >> step_i;
      SEL_LSL: result_o = data_i << step_i;
      SEL_ROR: result_o = ror_w[DATA_WIDTH-1:0];
      SEL_ROL: result_o = rol_w[2*DATA_WIDTH-1:DATA_WIDTH];
      SEL_ASR: result_o = unsigned'(asr_w);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Shares one 16-bit barrel shifter between two requesters. A round-robin
// arbiter accepts one operation at a time; shifts of 16..31 are built from
// up to three passes through the shifter, each pass's result becoming the
// next pass's operand. Results return on a valid/ready port tagged with the
// requester ID.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int AMT_WIDTH  = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [1:0]            ReqValid,
  output logic [1:0]            ReqReady,
  input  logic [2:0]            ReqSelect0,
  input  logic [2:0]            ReqSelect1,
  input  logic [AMT_WIDTH-1:0]  ReqAmount0,
  input  logic [AMT_WIDTH-1:0]  ReqAmount1,
  input  logic [DATA_WIDTH-1:0] ReqData0,
  input  logic [DATA_WIDTH-1:0] ReqData1,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [DATA_WIDTH-1:0] RespData,
  output logic                  RespId,
  output logic                  RespErr,
  output logic                  Busy
);

  // Total amount still to apply. Rotates wrap at the operand width so they
  // always finish in one pass; illegal selects run one zero-step pass.
  function automatic logic [AMT_WIDTH-1:0] pass_total(
    input logic [2:0]           sel,
    input logic [AMT_WIDTH-1:0] amt
  );
    if (!sel_is_legal(sel)) return '0;
    if (sel == SEL_ROR || sel == SEL_ROL) return AMT_WIDTH'(amt[STEP_W-1:0]);
    return amt;
  endfunction

  // Step for the current pass: the remaining amount clamped to MAX_STEP.
  function automatic logic [STEP_W-1:0] sat_step(input logic [AMT_WIDTH-1:0] rem);
    if (rem > AMT_WIDTH'(MAX_STEP)) return STEP_W'(MAX_STEP);
    return rem[STEP_W-1:0];
  endfunction

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [2:0]            sel_q, sel_d;
  logic [AMT_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  id_q, id_d;
  logic                  win_c;
  logic [STEP_W-1:0]     step_w;
  logic [DATA_WIDTH-1:0] shift_w;

  assign step_w = sat_step(rem_q);

  BarrelShifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .data_i   (data_q),
    .step_i   (step_w),
    .select_i (sel_q),
    .result_o (shift_w)
  );

  // Arbitration, pass sequencing and next-state selection.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    rem_d    = rem_q;
    data_d   = data_q;
    id_d     = id_q;
    win_c    = 1'b0;
    ReqReady = 2'b00;
    case (state_q)
      IDLE: begin
        if (|ReqValid) begin
          // Contention goes to the pointer; otherwise the lone requester.
          win_c    = (&ReqValid) ? ptr_q : ~ReqValid[0];
          ReqReady = win_c ? 2'b10 : 2'b01;
          id_d     = win_c;
          ptr_d    = ~win_c;
          sel_d    = win_c ? ReqSelect1 : ReqSelect0;
          data_d   = win_c ? ReqData1   : ReqData0;
          rem_d    = pass_total(sel_d, win_c ? ReqAmount1 : ReqAmount0);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        data_d = shift_w;
        rem_d  = rem_q - AMT_WIDTH'(step_w);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (RespReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage boundary: control state (reset) ----
  // Control registers: FSM state and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---- stage boundary: operation datapath (no reset) ----
  // Latched operation and the operand/remaining amount updated each pass.
  always_ff @(posedge Clk) begin
    sel_q  <= sel_d;
    rem_q  <= rem_d;
    data_q <= data_d;
    id_q   <= id_d;
  end

  // Response fields are forced to zero outside DONE so idle outputs match
  // the reset values without resetting the datapath registers.
  assign RespValid = (state_q == DONE);
  assign RespData  = RespValid ? data_q : '0;
  assign RespId    = RespValid & id_q;
  assign RespErr   = RespValid & ~sel_is_legal(sel_q);
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: table-driven single-requester vectors, a
// scoreboard monitor fed from observed accepts, and hand-written sequences
// for round-robin, response back-pressure and mid-operation reset.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  ReqValid;
  logic [1:0]  ReqReady;
  logic [2:0]  ReqSelect0, ReqSelect1;
  logic [4:0]  ReqAmount0, ReqAmount1;
  logic [15:0] ReqData0, ReqData1;
  logic        RespValid;
  logic        RespReady;
  logic [15:0] RespData;
  logic        RespId;
  logic        RespErr;
  logic        Busy;

  always #5 Clk = ~Clk;

  shift_sequencer #(
    .DATA_WIDTH (16),
    .AMT_WIDTH  (5)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqSelect0 (ReqSelect0),
    .ReqSelect1 (ReqSelect1),
    .ReqAmount0 (ReqAmount0),
    .ReqAmount1 (ReqAmount1),
    .ReqData0   (ReqData0),
    .ReqData1   (ReqData1),
    .RespValid  (RespValid),
    .RespReady  (RespReady),
    .RespData   (RespData),
    .RespId     (RespId),
    .RespErr    (RespErr),
    .Busy       (Busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] data;
    logic        id;
    logic        err;
    int          t;
    int          n;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        id;
    logic [2:0]  sel;
    logic [4:0]  amt;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_err;
    int          n;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result of the whole shift, computed in one step.
  function automatic logic [15:0] model_shift(input logic [2:0] sel, input logic [4:0] amt,
                                              input logic [15:0] d);
    logic [3:0] r;
    r = amt[3:0];
    case (sel)
      SEL_LSR: return (amt >= 5'd16) ? 16'h0000 : (d >> amt);
      SEL_LSL: return (amt >= 5'd16) ? 16'h0000 : (d << amt);
      SEL_ROR: return (r == 4'd0) ? d : ((d >> r) | (d << (5'd16 - {1'b0, r})));
      SEL_ROL: return (r == 4'd0) ? d : ((d << r) | (d >> (5'd16 - {1'b0, r})));
      SEL_ASR: return $unsigned($signed(d) >>> amt);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int model_passes(input logic [2:0] sel, input logic [4:0] amt);
    if (sel > SEL_ASR || sel == SEL_ROR || sel == SEL_ROL) return 1;
    if (amt <= 5'd15) return 1;
    if (amt <= 5'd30) return 2;
    return 3;
  endfunction

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Monitor: pushes expectations on observed accepts, compares responses.
  initial begin : monitor
    logic        resp_prev;
    logic        w;
    logic [2:0]  s;
    logic [4:0]  a;
    logic [15:0] d;
    exp_t        e;
    resp_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        resp_prev = 1'b0;
      end else begin
        check("req_ready_onehot0", 32'($onehot0(ReqReady)), 32'd1);
        check("req_ready_needs_valid", 32'(ReqReady & ~ReqValid), 32'd0);
        if (Busy) check("req_ready_while_busy", 32'(ReqReady), 32'd0);
        if (|(ReqReady & ReqValid)) begin
          w = ReqReady[1];
          s = w ? ReqSelect1 : ReqSelect0;
          a = w ? ReqAmount1 : ReqAmount0;
          d = w ? ReqData1   : ReqData0;
          e.data = model_shift(s, a, d);
          e.id   = w;
          e.err  = (s > SEL_ASR);
          e.t    = cyc;
          e.n    = model_passes(s, a);
          sb.push_back(e);
        end
        if (RespValid) begin
          if (sb.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            if (!resp_prev) check("sb_latency", 32'(cyc - e.t), 32'(e.n + 1));
            check("sb_resp_data", 32'(RespData), 32'(e.data));
            check("sb_resp_id", 32'(RespId), 32'(e.id));
            check("sb_resp_err", 32'(RespErr), 32'(e.err));
            if (RespReady) void'(sb.pop_front());
          end
        end
        resp_prev = RespValid;
      end
    end
  end

  task automatic drive_req(input logic id, input logic [2:0] sel, input logic [4:0] amt,
                           input logic [15:0] data);
    if (id) begin
      ReqSelect1 = sel; ReqAmount1 = amt; ReqData1 = data;
    end else begin
      ReqSelect0 = sel; ReqAmount0 = amt; ReqData0 = data;
    end
    ReqValid[id] = 1'b1;
  endtask

  task automatic wait_accept(input logic id, input string name);
    bit got;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge Clk);
      if (ReqReady[id]) got = 1;
    end
    if (!got) check(name, 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge Clk);
      if (sb.size() == 0 && !Busy) done = 1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(posedge Clk); #1;
  endtask

  // One table vector: accept, then count cycles to the response handshake.
  task automatic do_vec(input vec_t v, input int idx);
    bit got;
    drive_req(v.id, v.sel, v.amt, v.data);
    wait_accept(v.id, $sformatf("vec%0d_accept_timeout", idx));
    @(posedge Clk); #1;
    ReqValid[v.id] = 1'b0;
    got = 0;
    for (int k = 1; k < 50 && !got; k++) begin
      @(negedge Clk);
      if (RespValid && RespReady) begin
        got = 1;
        check($sformatf("vec%0d_latency", idx), 32'(k), 32'(v.n + 1));
        check($sformatf("vec%0d_data", idx), 32'(RespData), 32'(v.exp_data));
        check($sformatf("vec%0d_id", idx), 32'(RespId), 32'(v.id));
        check($sformatf("vec%0d_err", idx), 32'(RespErr), 32'(v.exp_err));
      end
    end
    if (!got) check($sformatf("vec%0d_resp_timeout", idx), 32'd0, 32'd1);
    @(posedge Clk); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vecs[0]  = '{1'b0, SEL_LSR, 5'd4,  16'h8001, 16'h0800, 1'b0, 1};
    vecs[1]  = '{1'b1, SEL_ASR, 5'd20, 16'h8000, 16'hFFFF, 1'b0, 2};
    vecs[2]  = '{1'b0, SEL_LSL, 5'd31, 16'h0001, 16'h0000, 1'b0, 3};
    vecs[3]  = '{1'b1, SEL_ROR, 5'd20, 16'h1234, 16'h4123, 1'b0, 1};
    vecs[4]  = '{1'b0, SEL_ROL, 5'd4,  16'h1234, 16'h2341, 1'b0, 1};
    vecs[5]  = '{1'b1, SEL_LSR, 5'd0,  16'hA5A5, 16'hA5A5, 1'b0, 1};
    vecs[6]  = '{1'b0, SEL_ASR, 5'd15, 16'h8000, 16'hFFFF, 1'b0, 1};
    vecs[7]  = '{1'b1, SEL_LSL, 5'd16, 16'hFFFF, 16'h0000, 1'b0, 2};
    vecs[8]  = '{1'b0, SEL_ASR, 5'd31, 16'h7FFF, 16'h0000, 1'b0, 3};
    vecs[9]  = '{1'b1, SEL_LSR, 5'd30, 16'hFFFF, 16'h0000, 1'b0, 2};
    vecs[10] = '{1'b0, SEL_ROL, 5'd17, 16'h8001, 16'h0003, 1'b0, 1};
    vecs[11] = '{1'b0, 3'b101,  5'd7,  16'h1234, 16'h0000, 1'b1, 1};
    vecs[12] = '{1'b1, SEL_ASR, 5'd17, 16'hC000, 16'hFFFF, 1'b0, 2};
    vecs[13] = '{1'b0, SEL_ASR, 5'd16, 16'h4000, 16'h0000, 1'b0, 2};
    vecs[14] = '{1'b1, SEL_LSL, 5'd7,  16'h0103, 16'h8180, 1'b0, 1};
    vecs[15] = '{1'b0, SEL_ROR, 5'd16, 16'hBEEF, 16'hBEEF, 1'b0, 1};

    Reset = 1'b1;
    ReqValid = 2'b00;
    ReqSelect0 = 3'b000; ReqSelect1 = 3'b000;
    ReqAmount0 = 5'd0;   ReqAmount1 = 5'd0;
    ReqData0 = 16'h0;    ReqData1 = 16'h0;
    RespReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    // Reset state.
    @(negedge Clk);
    check("rst_req_ready", 32'(ReqReady), 32'd0);
    check("rst_resp_valid", 32'(RespValid), 32'd0);
    check("rst_resp_data", 32'(RespData), 32'd0);
    check("rst_resp_id", 32'(RespId), 32'd0);
    check("rst_resp_err", 32'(RespErr), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    @(posedge Clk); #1;

    for (int i = 0; i < 16; i++) do_vec(vecs[i], i);
    drain();

    // Round-robin under continuous contention right after reset.
    Reset = 1'b1;
    drive_req(1'b0, SEL_LSR, 5'd0, 16'h1000);
    drive_req(1'b1, SEL_LSL, 5'd1, 16'h2001);
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] exp_rr;
      @(negedge Clk);
      exp_rr = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr_grant_k%0d", k), 32'(ReqReady), 32'(exp_rr));
    end
    @(posedge Clk); #1;
    ReqValid = 2'b00;
    drain();

    // Illegal select with the response held off; a waiting requester
    // must not be granted while the result is pending.
    RespReady = 1'b0;
    drive_req(1'b0, 3'b110, 5'd3, 16'hFFFF);
    wait_accept(1'b0, "illegal_accept_timeout");
    @(posedge Clk); #1;
    ReqValid[0] = 1'b0;
    drive_req(1'b1, SEL_LSR, 5'd1, 16'h0002);
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge Clk);
        if (RespValid) got = 1;
      end
      if (!got) check("illegal_resp_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clk);
      check("hold_resp_valid", 32'(RespValid), 32'd1);
      check("hold_resp_data", 32'(RespData), 32'd0);
      check("hold_resp_err", 32'(RespErr), 32'd1);
      check("hold_resp_id", 32'(RespId), 32'd0);
      check("hold_req_ready", 32'(ReqReady), 32'd0);
    end
    @(posedge Clk); #1;
    RespReady = 1'b1;
    wait_accept(1'b1, "waiting_req_accept_timeout");
    @(posedge Clk); #1;
    ReqValid[1] = 1'b0;
    drain();

    // Reset during the first pass of a three-pass operation.
    drive_req(1'b0, SEL_LSL, 5'd31, 16'h0001);
    wait_accept(1'b0, "rstexec_accept_timeout");
    @(posedge Clk); #1;
    ReqValid[0] = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    sb.delete();
    @(negedge Clk);
    check("rstexec_busy", 32'(Busy), 32'd0);
    check("rstexec_resp_valid", 32'(RespValid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      check("rstexec_no_resp", 32'(RespValid), 32'd0);
    end
    @(posedge Clk); #1;
    drive_req(1'b0, SEL_LSR, 5'd1, 16'h0004);
    drive_req(1'b1, SEL_ROL, 5'd1, 16'h8000);
    @(negedge Clk);
    check("rstexec_ptr_req0", 32'(ReqReady), 32'd1);
    @(posedge Clk); #1;
    ReqValid[0] = 1'b0;
    wait_accept(1'b1, "rstexec_req1_accept_timeout");
    @(posedge Clk); #1;
    ReqValid[1] = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
